// File: rtl/io_cond_pkg.sv
// Shared sizing constants and helpers for the board input conditioning path.
package io_cond_pkg;

  localparam int SW_WIDTH            = 10;
  localparam int KEY_WIDTH           = 2;
  localparam int DEBOUNCE_10MS_50MHZ = 500000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input channel: two-flop synchroniser, polarity fix, debounce counter, edge strobes.
// Optional sticky change flag when INPUT_CHANGE_STICKY_EN is defined.
module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
`ifdef INPUT_CHANGE_STICKY_EN
  ,
  output logic changed,
  input  logic clear
`endif
);

  localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_p0;
  logic          s2_p1;
  logic          pol_p1;
  logic [CW-1:0] cnt_p2;

  assign pol_p1 = s2_p1 ^ ACTIVE_LOW;

  // stage p0/p1: synchroniser, parked at the inactive pin level during reset
  // stage p2: debounce count, accepted level and one-cycle strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0  <= ACTIVE_LOW;
      s2_p1  <= ACTIVE_LOW;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      cnt_p2 <= '0;
    end else begin
      s1_p0 <= raw;
      s2_p1 <= s1_p0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (pol_p1 == level) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == TERM) begin
        level  <= pol_p1;
        cnt_p2 <= '0;
        rise   <= pol_p1;
        fall   <= ~pol_p1;
      end else begin
        cnt_p2 <= cnt_p2 + 1'b1;
      end
    end
  end

`ifdef INPUT_CHANGE_STICKY_EN
  // stage p3: a strobe seen this cycle sets the flag even if clear is also high
  always_ff @(posedge clk) begin
    if (reset) begin
      changed <= 1'b0;
    end else if (rise || fall) begin
      changed <= 1'b1;
    end else if (clear) begin
      changed <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/input_conditioner.sv
// Debounced, polarity-corrected board switch/key inputs with edge strobes.
// Define INPUT_CHANGE_STICKY_EN to add changed_flags / flags_clear.
module input_conditioner
  import io_cond_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
`ifdef INPUT_CHANGE_STICKY_EN
  ,
  output logic [WIDTH-1:0] changed_flags,
  input  logic [WIDTH-1:0] flags_clear
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_in[i]),
      .level  (level_out[i]),
      .rise   (rise_pulse[i]),
      .fall   (fall_pulse[i])
`ifdef INPUT_CHANGE_STICKY_EN
      ,
      .changed(changed_flags[i]),
      .clear  (flags_clear[i])
`endif
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed + randomized bench for input_conditioner against a time-stamp based reference.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] raw_a, raw_c;
  logic [1:0] raw_b;
  logic [9:0] clr_a;
  logic [9:0] level_a, rise_a, fall_a, level_c, rise_c, fall_c;
  logic [1:0] level_b, rise_b, fall_b;
`ifdef INPUT_CHANGE_STICKY_EN
  logic [9:0] changed_a, changed_c;
  logic [1:0] changed_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign raw_c = raw_a;

  input_conditioner #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset), .raw_in(raw_a),
    .level_out(level_a), .rise_pulse(rise_a), .fall_pulse(fall_a)
`ifdef INPUT_CHANGE_STICKY_EN
    , .changed_flags(changed_a), .flags_clear(clr_a)
`endif
  );

  input_conditioner #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .raw_in(raw_b),
    .level_out(level_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
`ifdef INPUT_CHANGE_STICKY_EN
    , .changed_flags(changed_b), .flags_clear(2'b00)
`endif
  );

  input_conditioner #(.WIDTH(10), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .reset(reset), .raw_in(raw_c),
    .level_out(level_c), .rise_pulse(rise_c), .fall_pulse(fall_c)
`ifdef INPUT_CHANGE_STICKY_EN
    , .changed_flags(changed_c), .flags_clear(10'h000)
`endif
  );

  // Reference: a bit's level flips once its corrected input has disagreed with it
  // for d consecutive edges, i.e. d edges since the last edge where they agreed.
  logic [9:0] ms1 [3];
  logic [9:0] ms2 [3];
  logic [9:0] mlev [3];
  logic [9:0] mrise [3];
  logic [9:0] mfall [3];
  logic [9:0] mflag [3];
  int         agree [3][10];
  int         nedge = 0;

  task automatic model_edge(input int k, input int w, input int d, input bit al,
                            input logic [9:0] raw, input logic rst, input logic [9:0] clr);
    for (int i = 0; i < w; i++) begin
      logic p, pr, pf;
      pr = mrise[k][i];
      pf = mfall[k][i];
      if (rst) begin
        ms1[k][i] = al; ms2[k][i] = al; mlev[k][i] = 1'b0;
        mrise[k][i] = 1'b0; mfall[k][i] = 1'b0; mflag[k][i] = 1'b0;
        agree[k][i] = nedge;
      end else begin
        p = ms2[k][i] ^ al;
        mrise[k][i] = 1'b0;
        mfall[k][i] = 1'b0;
        if (p == mlev[k][i]) agree[k][i] = nedge;
        else if (nedge - agree[k][i] == d) begin
          mlev[k][i]  = p;
          agree[k][i] = nedge;
          mrise[k][i] = p;
          mfall[k][i] = ~p;
        end
        ms2[k][i] = ms1[k][i];
        ms1[k][i] = raw[i];
        if (pr || pf) mflag[k][i] = 1'b1;
        else if (clr[i]) mflag[k][i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 10, 4, 1'b0, raw_a, reset, clr_a);
    model_edge(1, 2, 4, 1'b1, {8'h00, raw_b}, reset, 10'h000);
    model_edge(2, 10, 1, 1'b0, raw_c, reset, 10'h000);
    nedge++;
  end

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("model_level_a", level_a, mlev[0]);
    chk("model_rise_a", rise_a, mrise[0]);
    chk("model_fall_a", fall_a, mfall[0]);
    chk("model_level_b", {8'h00, level_b}, {8'h00, mlev[1][1:0]});
    chk("model_rise_b", {8'h00, rise_b}, {8'h00, mrise[1][1:0]});
    chk("model_fall_b", {8'h00, fall_b}, {8'h00, mfall[1][1:0]});
    chk("model_level_c", level_c, mlev[2]);
    chk("model_rise_c", rise_c, mrise[2]);
    chk("model_fall_c", fall_c, mfall[2]);
    chk("never_both_a", rise_a & fall_a, 10'h000);
`ifdef INPUT_CHANGE_STICKY_EN
    chk("model_flags_a", changed_a, mflag[0]);
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 10'h3FF;
    raw_b = 2'b11;
    clr_a = 10'h000;
    step(3);
    chk("reset_level_a", level_a, 10'h000);
    chk("reset_rise_a", rise_a, 10'h000);
    chk("reset_level_b", {8'h00, level_b}, 10'h000);

    // reset exit with pins already active
    reset = 1'b0;
    step(2);
    chk("dc1_level_e2", level_c, 10'h000);
    step(1);
    chk("dc1_level_e3", level_c, 10'h3FF);
    chk("dc1_rise_e3", rise_c, 10'h3FF);
    step(2);
    chk("exit_level_e5", level_a, 10'h000);
    chk("exit_rise_e5", rise_a, 10'h000);
    step(1);
    chk("exit_level_e6", level_a, 10'h3FF);
    chk("exit_rise_e6", rise_a, 10'h3FF);
    chk("exit_fall_e6", fall_a, 10'h000);
    step(1);
    chk("exit_rise_e7", rise_a, 10'h000);
    chk("idle_key_level", {8'h00, level_b}, 10'h000);
`ifdef INPUT_CHANGE_STICKY_EN
    chk("flags_after_exit", changed_a, 10'h3FF);
`endif

    // single-bit accepted change
    raw_a = 10'h000;
    step(8);
    chk("settle_low", level_a, 10'h000);
    raw_a = 10'h008;
    step(5);
    chk("bit3_e5", level_a, 10'h000);
    step(1);
    chk("bit3_e6_level", level_a, 10'h008);
    chk("bit3_e6_rise", rise_a, 10'h008);
    step(1);
    chk("bit3_e7_rise", rise_a, 10'h000);

    // 3-cycle glitch rejected, then a held change accepted
    raw_a = 10'h009;
    step(3);
    raw_a = 10'h008;
    step(8);
    chk("glitch_level", level_a, 10'h008);
    raw_a = 10'h009;
    step(6);
    chk("hold_level", level_a, 10'h009);
    chk("hold_rise", rise_a, 10'h001);

    // reset in the middle of a count
    raw_a = 10'h029;
    step(5);
    reset = 1'b1;
    step(1);
    chk("midreset_level", level_a, 10'h000);
    chk("midreset_rise", rise_a, 10'h000);
    reset = 1'b0;
    step(5);
    chk("after_reset_e5", level_a, 10'h000);
    step(1);
    chk("after_reset_e6", level_a, 10'h029);
    chk("after_reset_rise", rise_a, 10'h029);

    // active-low key press and release
    raw_b = 2'b01;
    step(5);
    chk("key_press_e5", {8'h00, level_b}, 10'h000);
    step(1);
    chk("key_press_level", {8'h00, level_b}, 10'h002);
    chk("key_press_rise", {8'h00, rise_b}, 10'h002);
    step(1);
    chk("key_press_rise_off", {8'h00, rise_b}, 10'h000);
    raw_b = 2'b11;
    step(6);
    chk("key_release_level", {8'h00, level_b}, 10'h000);
    chk("key_release_fall", {8'h00, fall_b}, 10'h002);
    step(1);
    chk("key_release_fall_off", {8'h00, fall_b}, 10'h000);

    // randomized toggling: mix of glitches and accepted changes
    for (int it = 0; it < 200; it++) begin
      raw_a = raw_a ^ 10'($urandom & $urandom);
      raw_b = raw_b ^ 2'($urandom & $urandom);
`ifdef INPUT_CHANGE_STICKY_EN
      clr_a = 10'($urandom & $urandom & $urandom);
`endif
      step($urandom_range(1, 7));
    end
    clr_a = 10'h000;

`ifdef INPUT_CHANGE_STICKY_EN
    raw_a = 10'h000;
    step(10);
    clr_a = 10'h3FF;
    step(1);
    clr_a = 10'h000;
    chk("flags_cleared", changed_a, 10'h000);
    raw_a = 10'h004;
    step(6);
    chk("sticky_rise", rise_a, 10'h004);
    step(1);
    chk("sticky_set", changed_a, 10'h004);
    step(3);
    chk("sticky_held", changed_a, 10'h004);
    raw_a = 10'h000;
    step(6);
    chk("sticky_fall", fall_a, 10'h004);
    clr_a = 10'h004;
    step(1);
    clr_a = 10'h000;
    chk("sticky_set_wins", changed_a, 10'h004);
    step(2);
    clr_a = 10'h004;
    step(1);
    clr_a = 10'h000;
    chk("sticky_lone_clear", changed_a, 10'h000);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
